// File: rtl/vga_timing_pkg.sv
// Timing descriptor type and helpers shared by the framebuffer scan engine.
// Optional macro SCALE2X_EN selects a half-resolution framebuffer (FB_DIV = 2).
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_timing_t;

`ifdef SCALE2X_EN
    localparam int unsigned FB_DIV = 2;
`else
    localparam int unsigned FB_DIV = 1;
`endif

    function automatic int unsigned total(input vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int unsigned fb_size(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    function automatic logic in_active(input int unsigned cnt, input vga_timing_t t);
        return cnt < t.active;
    endfunction

    function automatic logic in_sync(input int unsigned cnt, input vga_timing_t t);
        return (cnt >= t.active + t.fp) && (cnt < t.active + t.fp + t.sync);
    endfunction

endpackage

// File: rtl/fb_scan_reader_wrap_counter.sv
// Modulo-(MAX+1) counter with clock enable, clear and a terminal-count wrap pulse.
// Behaviour is independent of SCALE2X_EN.
module wrap_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         ce,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (ce) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + W'(1);
        end
    end

    assign count = count_reg;
    assign wrap  = ce && (count_reg == LAST);

endmodule

// File: rtl/fb_scan_reader.sv
// Framebuffer scan engine: VGA timing, linear RAM read addressing and pixel/sync realignment.
// Define SCALE2X_EN to scan a half-resolution framebuffer with 2x pixel/line replication.
module fb_scan_reader
    import vga_timing_pkg::*;
#(
    parameter int   ADDR_W   = 16,
    parameter int   DATA_W   = 8,
    parameter int   H_ACTIVE = 256,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 32,
    parameter int   H_BP     = 16,
    parameter int   V_ACTIVE = 256,
    parameter int   V_FP     = 4,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 18,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_ce,
    input  logic              enable,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] pixel,
    output logic              pixel_valid,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    localparam vga_timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam vga_timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int H_TOTAL = int'(total(H_T));
    localparam int V_TOTAL = int'(total(V_T));
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int unsigned FB_SIZE    = fb_size(H_ACTIVE / FB_DIV, V_ACTIVE / FB_DIV);
    localparam int unsigned H_LAST_ACT = H_ACTIVE - 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FB_SIZE - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, v_wrap;
    logic          advance;
    int unsigned   h_pos, v_pos;
    logic          active, hs_region, vs_region;

    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] pixel_reg;
    logic              valid_reg, hsync_reg, vsync_reg, frame_start_reg;

    assign advance = pix_ce && enable;

    wrap_counter #(.W(HW), .MAX(H_TOTAL - 1)) u_h_cnt (
        .clk   (clk),
        .srst  (reset),
        .ce    (advance),
        .clr   (!enable),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    wrap_counter #(.W(VW), .MAX(V_TOTAL - 1)) u_v_cnt (
        .clk   (clk),
        .srst  (reset),
        .ce    (advance && h_wrap),
        .clr   (!enable),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    assign h_pos     = 32'(h_cnt);
    assign v_pos     = 32'(v_cnt);
    assign active    = in_active(h_pos, H_T) && in_active(v_pos, V_T);
    assign hs_region = in_sync(h_pos, H_T);
    assign vs_region = in_sync(v_pos, V_T);

`ifdef SCALE2X_EN
    logic [ADDR_W-1:0] line_base_reg, line_base_next;
    logic [ADDR_W-1:0] row_next;

    assign row_next = (addr_reg == ADDR_LAST) ? '0 : addr_reg + ADDR_W'(1);

    // Addresses step on odd columns; at line end an even line rewinds to its
    // row start so the odd line replays it, and an odd line moves on a row.
    always_comb begin
        addr_next      = addr_reg;
        line_base_next = line_base_reg;
        if (v_wrap) begin
            addr_next      = '0;
            line_base_next = '0;
        end else if (active && h_cnt[0]) begin
            if (h_pos == H_LAST_ACT) begin
                if (!v_cnt[0]) begin
                    addr_next = line_base_reg;
                end else begin
                    addr_next      = row_next;
                    line_base_next = row_next;
                end
            end else begin
                addr_next = addr_reg + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            line_base_reg <= '0;
        end else if (advance) begin
            line_base_reg <= line_base_next;
        end
    end
`else
    // The last active pixel folds straight back to 0, so the address never
    // leaves the framebuffer even when its size is not a power of two.
    always_comb begin
        addr_next = addr_reg;
        if (v_wrap) begin
            addr_next = '0;
        end else if (active) begin
            addr_next = (addr_reg == ADDR_LAST) ? '0 : addr_reg + ADDR_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            addr_reg <= '0;
        end else if (advance) begin
            addr_reg <= addr_next;
        end
    end

    // ram_q for the current address is valid by the next strobe, so outputs
    // are captured from the counters as they stand, one strobe late.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            pixel_reg       <= '0;
            valid_reg       <= 1'b0;
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            if (advance) begin
                pixel_reg       <= active ? ram_q : '0;
                valid_reg       <= active;
                hsync_reg       <= hs_region ? SYNC_POL : ~SYNC_POL;
                vsync_reg       <= vs_region ? SYNC_POL : ~SYNC_POL;
                frame_start_reg <= (h_cnt == '0) && (v_cnt == '0);
            end
        end
    end

    assign ram_addr    = addr_reg;
    assign pixel       = pixel_reg;
    assign pixel_valid = valid_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign frame_start = frame_start_reg;

endmodule
